add_arb: RTL and testbench
==========================

# add_arb

Two-port arbiter and sequencer for the shared 32-bit adder datapath. It lets the fetch-side PC incrementer (port 0) and the execute stage (port 1) share one adder. Requests enter through valid/ready handshakes, are arbitrated round-robin, and are computed in the grant cycle. Each result is registered into a per-port response slot and returned through its own valid/ready handshake.

## Interface
- DATAWIDTH, 32: operand and result width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- r0_valid  in  1  port 0 request valid.
- r0_ready  out  1  port 0 request accepted this cycle.
- r0_a, r0_b  in  DATAWIDTH  port 0 operands.
- r0_sub  in  1  port 0 op: 0 = a+b, 1 = a-b.
- r1_valid, r1_ready, r1_a, r1_b, r1_sub: same meanings for port 1.
- rsp0_valid  out  1  port 0 result slot full.
- rsp0_ready  in  1  port 0 consumer takes the result.
- rsp0_data  out  DATAWIDTH  port 0 result.
- rsp1_valid, rsp1_ready, rsp1_data: same meanings for port 1.

## Operation
- Adder computes a + b, or a + ~b + 1 when sub = 1.
- All arithmetic wraps modulo 2^DATAWIDTH. There is no carry or overflow output.
- Only one operation is issued per cycle, on the single shared adder instance.
- Eligibility: elig_i = ri_valid && (!rspi_valid || rspi_ready).
  - A port whose response slot is full and not draining this cycle is not eligible.
- Grant:
  - Only one port eligible: grant that port.
  - Both eligible: grant the port that is not `last`.
- ri_ready = grant_i. This is combinational from ri_valid and the slot state. A requester must not make valid depend on ready.
- Requesters hold valid, operands and sub stable until accepted.
- On a grant to port i at a clock edge:
  - `last` <- i.
  - rspi_data <- adder result.
  - rspi_valid <- 1.
- On rspi_valid && rspi_ready with no new grant to port i: rspi_valid <- 0.
- If both happen on port i in the same cycle, the slot is refilled: valid stays 1 and data takes the new result.
- rspi_data holds its value while rspi_valid = 1 and rspi_ready = 0.
- rspi_data after a drain is don't-care; benches check data only when valid.
- Each port's response slot is independent. Backpressure on one port never blocks the other port.
- State: `last` (1 bit), rsp0_valid, rsp1_valid, rsp0_data, rsp1_data.

## Timing
- Reset (asynchronous assertion, any time) forces:
  - rsp0_valid = 0, rsp1_valid = 0.
  - rsp0_data = 0, rsp1_data = 0.
  - last = 1, so port 0 wins the first tie.
- Outputs while reset is held:
  - r0_ready = r1_ready = 0 as long as requests are low. Grant logic is combinational, so requesters must keep valid low during reset.
  - No grant is committed while rst_n = 0.
- Reset mid-operation discards any accepted-but-unconsumed result.
- Deassertion is synchronized externally; the first edge after deassertion can grant.
- Latency: request accepted at edge N gives rspi_valid = 1 after edge N.
  - Result is visible in cycle N+1.
  - One cycle of latency, independent of the other port.
- Throughput:
  - One result per cycle total.
  - A single active port with consumer always ready gets one result per cycle.
  - Two continuously active ports alternate 0,1,0,1… when both consumers are ready.
- Tie when only one slot can accept: the eligible port wins and `last` updates to it.
- An ungranted valid request stays pending with ri_ready = 0. Nothing is dropped.

## Test plan
- Reset check: assert rst_n = 0 mid-stream with rsp0_valid = 1 -> rsp0_valid = 0, rsp0_data = 0 immediately, without waiting for a clock edge. First tie after release is granted to port 0.
- Single add: r0 = {a=0x5, b=0x3, sub=0}, rsp0_ready = 1 -> r0_ready = 1 in cycle 0; rsp0_valid = 1, rsp0_data = 0x8 in cycle 1.
- Wrap and subtract on port 1:
  - 0xFFFFFFFF + 0x1 -> 0x00000000.
  - 0x3 - 0x5 (sub=1) -> 0xFFFFFFFE.
- Contention: both ports valid every cycle for 6 cycles, both consumers ready -> grants 0,1,0,1,0,1, each result correct and one cycle after its grant.
- Backpressure:
  - rsp1_ready = 0 with rsp1_valid = 1 and r1_valid = 1 -> r1_ready = 0 and rsp1_data is stable.
  - Port 0 is still served every cycle.
  - Raising rsp1_ready lets port 1 drain, with the refill accepted in the same cycle.
- Refill: rsp0_valid = 1, rsp0_ready = 1, new r0 request {0x10, 0x20} -> rsp0_valid stays 1 and rsp0_data = 0x30 next cycle.

Source files
------------

// File: rtl/add_arb_if.sv
// add_arb_if: request and response handshakes of the two adder client ports
interface add_arb_if #(
    parameter int DATAWIDTH = 32
);
    logic                 r0_valid;
    logic                 r0_ready;
    logic [DATAWIDTH-1:0] r0_a;
    logic [DATAWIDTH-1:0] r0_b;
    logic                 r0_sub;
    logic                 r1_valid;
    logic                 r1_ready;
    logic [DATAWIDTH-1:0] r1_a;
    logic [DATAWIDTH-1:0] r1_b;
    logic                 r1_sub;
    logic                 rsp0_valid;
    logic                 rsp0_ready;
    logic [DATAWIDTH-1:0] rsp0_data;
    logic                 rsp1_valid;
    logic                 rsp1_ready;
    logic [DATAWIDTH-1:0] rsp1_data;

    modport master (
        output r0_valid, r0_a, r0_b, r0_sub,
        output r1_valid, r1_a, r1_b, r1_sub,
        output rsp0_ready, rsp1_ready,
        input  r0_ready, r1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_sub,
        input  r1_valid, r1_a, r1_b, r1_sub,
        input  rsp0_ready, rsp1_ready,
        output r0_ready, r1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
    );
endinterface

// File: rtl/add_arb.sv
// add_arb: round-robin sharing of one adder between two ports with per-port result slots
module add_arb #(
    parameter int DATAWIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    add_arb_if.slave bus
);
    logic                 last;
    logic                 v0;
    logic                 v1;
    logic [DATAWIDTH-1:0] d0;
    logic [DATAWIDTH-1:0] d1;
    logic                 elig0;
    logic                 elig1;
    logic                 gnt0;
    logic                 gnt1;
    logic [DATAWIDTH-1:0] op_a;
    logic [DATAWIDTH-1:0] op_b;
    logic                 op_sub;
    logic [DATAWIDTH-1:0] sum;

    // eligibility, round-robin grant and the single shared adder fed by the winner
    always_comb begin
        elig0  = bus.r0_valid && (!v0 || bus.rsp0_ready);
        elig1  = bus.r1_valid && (!v1 || bus.rsp1_ready);
        gnt0   = elig0 && (!elig1 || last);
        gnt1   = elig1 && (!elig0 || !last);
        op_a   = gnt1 ? bus.r1_a : bus.r0_a;
        op_b   = gnt1 ? bus.r1_b : bus.r0_b;
        op_sub = gnt1 ? bus.r1_sub : bus.r0_sub;
        sum    = op_a + (op_sub ? ~op_b : op_b) + {{(DATAWIDTH-1){1'b0}}, op_sub};
    end

    // last-winner pointer and response slots; a grant refills a slot even while it drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
            v0   <= 1'b0;
            v1   <= 1'b0;
            d0   <= '0;
            d1   <= '0;
        end else begin
            if (gnt0 || gnt1) last <= gnt1;
            v0 <= gnt0 || (v0 && !bus.rsp0_ready);
            v1 <= gnt1 || (v1 && !bus.rsp1_ready);
            if (gnt0) d0 <= sum;
            if (gnt1) d1 <= sum;
        end
    end

    assign bus.r0_ready   = gnt0;
    assign bus.r1_ready   = gnt1;
    assign bus.rsp0_valid = v0;
    assign bus.rsp1_valid = v1;
    assign bus.rsp0_data  = d0;
    assign bus.rsp1_data  = d1;
endmodule

// File: tb/tb_add_arb.sv
// tb_add_arb: directed checks of arbitration, arithmetic, backpressure, refill and reset
module tb_add_arb;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic [31:0] a0, b0, a1, b1;

    add_arb_if #(.DATAWIDTH(32)) bus ();

    add_arb #(.DATAWIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.r0_valid = v;
        bus.r0_a     = a;
        bus.r0_b     = b;
        bus.r0_sub   = s;
    endtask

    task automatic req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.r1_valid = v;
        bus.r1_a     = a;
        bus.r1_b     = b;
        bus.r1_sub   = s;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b1;
        req0(1'b0, '0, '0, 1'b0);
        req1(1'b0, '0, '0, 1'b0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_v0", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("rst_v1", {31'd0, bus.rsp1_valid}, 32'd0);
        chk("rst_d0", bus.rsp0_data, 32'd0);
        chk("rst_d1", bus.rsp1_data, 32'd0);
        tick();
        tick();
        chk("rst_rdy", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
        rst_n = 1'b1;

        // single add on port 0
        req0(1'b1, 32'h5, 32'h3, 1'b0);
        bus.rsp0_ready = 1'b1;
        #1;
        chk("add_rdy0", {31'd0, bus.r0_ready}, 32'd1);
        chk("add_rdy1", {31'd0, bus.r1_ready}, 32'd0);
        tick();
        req0(1'b0, '0, '0, 1'b0);
        chk("add_v0", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("add_d0", bus.rsp0_data, 32'h8);
        tick();
        chk("drain_v0", {31'd0, bus.rsp0_valid}, 32'd0);

        // wrap and subtract on port 1
        req1(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
        bus.rsp1_ready = 1'b1;
        #1;
        chk("wrap_rdy1", {31'd0, bus.r1_ready}, 32'd1);
        tick();
        chk("wrap_v1", {31'd0, bus.rsp1_valid}, 32'd1);
        chk("wrap_d1", bus.rsp1_data, 32'h0);
        req1(1'b1, 32'h3, 32'h5, 1'b1);
        #1;
        chk("sub_rdy1", {31'd0, bus.r1_ready}, 32'd1);
        tick();
        req1(1'b0, '0, '0, 1'b0);
        chk("sub_d1", bus.rsp1_data, 32'hFFFF_FFFE);
        tick();

        // contention: both ports every cycle, expect 0,1,0,1,0,1
        a0 = 32'd1;    b0 = 32'd100;
        a1 = 32'd1000; b1 = 32'd7;
        for (int i = 0; i < 6; i++) begin
            req0(1'b1, a0, b0, 1'b0);
            req1(1'b1, a1, b1, 1'b1);
            #1;
            chk($sformatf("cont%0d_rdy", i), {30'd0, bus.r1_ready, bus.r0_ready},
                (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
            if (i % 2 == 0) begin
                chk($sformatf("cont%0d_v0", i), {31'd0, bus.rsp0_valid}, 32'd1);
                chk($sformatf("cont%0d_d0", i), bus.rsp0_data, a0 + b0);
                a0 = a0 + 32'd3;
            end else begin
                chk($sformatf("cont%0d_v1", i), {31'd0, bus.rsp1_valid}, 32'd1);
                chk($sformatf("cont%0d_d1", i), bus.rsp1_data, a1 - b1);
                b1 = b1 + 32'd5;
            end
        end
        req0(1'b0, '0, '0, 1'b0);
        req1(1'b0, '0, '0, 1'b0);
        tick();

        // backpressure on port 1 while port 0 keeps flowing
        bus.rsp1_ready = 1'b0;
        req1(1'b1, 32'd7, 32'd2, 1'b0);
        #1;
        chk("bp_fill_rdy1", {31'd0, bus.r1_ready}, 32'd1);
        tick();
        chk("bp_fill_d1", bus.rsp1_data, 32'd9);
        req1(1'b1, 32'd20, 32'd1, 1'b0);
        a0 = 32'h40;
        for (int i = 0; i < 3; i++) begin
            req0(1'b1, a0, 32'h100, 1'b0);
            #1;
            chk($sformatf("bp%0d_rdy", i), {30'd0, bus.r1_ready, bus.r0_ready}, 32'd1);
            tick();
            chk($sformatf("bp%0d_v1", i), {31'd0, bus.rsp1_valid}, 32'd1);
            chk($sformatf("bp%0d_d1", i), bus.rsp1_data, 32'd9);
            chk($sformatf("bp%0d_d0", i), bus.rsp0_data, a0 + 32'h100);
            a0 = a0 + 32'd1;
        end
        req0(1'b1, a0, 32'h100, 1'b0);
        bus.rsp1_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd2);
        tick();
        chk("bp_rel_v1", {31'd0, bus.rsp1_valid}, 32'd1);
        chk("bp_rel_d1", bus.rsp1_data, 32'd21);
        chk("bp_rel_v0", {31'd0, bus.rsp0_valid}, 32'd0);
        req1(1'b0, '0, '0, 1'b0);
        #1;
        chk("bp_pend_rdy0", {31'd0, bus.r0_ready}, 32'd1);
        tick();
        chk("bp_pend_d0", bus.rsp0_data, a0 + 32'h100);

        // refill of a draining slot, then hold under backpressure
        req0(1'b1, 32'h10, 32'h20, 1'b0);
        #1;
        chk("refill_rdy0", {31'd0, bus.r0_ready}, 32'd1);
        tick();
        chk("refill_v0", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("refill_d0", bus.rsp0_data, 32'h30);
        req0(1'b0, '0, '0, 1'b0);
        bus.rsp0_ready = 1'b0;
        tick();
        tick();
        chk("hold_v0", {31'd0, bus.rsp0_valid}, 32'd1);
        chk("hold_d0", bus.rsp0_data, 32'h30);

        // asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_v0", {31'd0, bus.rsp0_valid}, 32'd0);
        chk("mrst_d0", bus.rsp0_data, 32'd0);
        chk("mrst_d1", bus.rsp1_data, 32'd0);
        tick();
        chk("mrst_hold_v0", {31'd0, bus.rsp0_valid}, 32'd0);
        rst_n = 1'b1;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        req0(1'b1, 32'd2, 32'd2, 1'b0);
        req1(1'b1, 32'd9, 32'd4, 1'b1);
        #1;
        chk("tie_rdy", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd1);
        tick();
        chk("tie_d0", bus.rsp0_data, 32'd4);
        chk("tie_v1", {31'd0, bus.rsp1_valid}, 32'd0);
        req0(1'b1, 32'd3, 32'd3, 1'b0);
        #1;
        chk("tie2_rdy", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd2);
        tick();
        chk("tie2_d1", bus.rsp1_data, 32'd5);
        req0(1'b0, '0, '0, 1'b0);
        req1(1'b0, '0, '0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
